// File: rtl/fetch_unit_if.sv
// fetch_unit_if: signal bundle between the fetch stage, instruction memory
// and decode.
//   master modport: fetch stage side (drives ImemReq/ImemAddr and the decode
//                   outputs; receives imem responses, consume and redirects).
//   slave  modport: environment side (imem + decode/control).
interface fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    // instruction memory request/response
    logic            ImemReq;
    logic [XLEN-1:0] ImemAddr;
    logic            ImemReady;
    logic            ImemRspValid;
    logic [XLEN-1:0] ImemRdata;
    // decode handshake
    logic            InstrValid;
    logic            InstrReady;
    logic [XLEN-1:0] Instr;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    // next-PC control and redirects
    logic            PCSrc;
    logic [XLEN-1:0] PCTarget;
    logic            Flush;
    logic [XLEN-1:0] FlushPC;
    // status
    logic            MisalignErr;
    logic [31:0]     InstRetCnt;

    modport master (
        output ImemReq, ImemAddr, InstrValid, Instr, PC, PCPlus4,
               MisalignErr, InstRetCnt,
        input  ImemReady, ImemRspValid, ImemRdata, InstrReady,
               PCSrc, PCTarget, Flush, FlushPC
    );

    modport slave (
        input  ImemReq, ImemAddr, InstrValid, Instr, PC, PCPlus4,
               MisalignErr, InstRetCnt,
        output ImemReady, ImemRspValid, ImemRdata, InstrReady,
               PCSrc, PCTarget, Flush, FlushPC
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32 instruction fetch stage. Holds the PC, issues one
// outstanding imem request at a time and hands Instr/PC/PCPlus4 to decode
// over a valid/ready handshake. Flush redirects with highest priority;
// a misaligned next PC halts fetch until the next Flush.
// Ports:
//   clk   - core clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - fetch_unit_if.master (imem bus, decode handshake, redirects)
// Optional feature: define FETCH_PERF_CNT_EN to build the retired
// instruction counter (InstRetCnt); otherwise InstRetCnt is tied to 0.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_VALID,
        S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;
    logic            discard_q, discard_d;

    logic            accept_c;
    logic            consume_c;
    logic [XLEN-1:0] next_pc_c;

    // alignment bits of redirect addresses are dropped by design
    logic unused_bits_c;
    assign unused_bits_c = ^{bus.FlushPC[1:0], bus.PCTarget[0]};

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + PC_STEP;
            instr_q    <= NOP_INSTR;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            discard_q  <= discard_d;
        end
    end

    // next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        discard_d  = discard_q;
        misalign_d = 1'b0;

        // req_q is only ever high in FETCH, so this is the imem handshake
        accept_c  = req_q & bus.ImemReady;
        consume_c = valid_q & bus.InstrReady;
        next_pc_c = bus.PCSrc ? {bus.PCTarget[XLEN-1:1], 1'b0} : pc_plus4_q;

        if (bus.Flush) begin
            pc_d = {bus.FlushPC[XLEN-1:2], 2'b00};
            unique case (state_q)
                S_FETCH: begin
                    // an accepted request still returns data: drop it
                    if (accept_c) begin
                        discard_d = 1'b1;
                        state_d   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.ImemRspValid) begin
                        discard_d = 1'b0;
                        state_d   = S_FETCH;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (accept_c) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.ImemRspValid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_FETCH;
                        end else begin
                            instr_d = bus.ImemRdata;
                            state_d = S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (consume_c) begin
                        if (next_pc_c[1]) begin
                            misalign_d = 1'b1;
                            state_d    = S_HALT;
                        end else begin
                            pc_d    = next_pc_c;
                            state_d = S_FETCH;
                        end
                    end
                end
                default: state_d = S_HALT;
            endcase
        end

        pc_plus4_d = pc_d + PC_STEP;
        req_d      = (state_d == S_FETCH);
        valid_d    = (state_d == S_VALID);
    end

    assign bus.ImemReq     = req_q;
    assign bus.ImemAddr    = pc_q;
    assign bus.InstrValid  = valid_q;
    assign bus.Instr       = instr_q;
    assign bus.PC          = pc_q;
    assign bus.PCPlus4     = pc_plus4_q;
    assign bus.MisalignErr = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    // retired-instruction counter; a flushed consume does not retire
    logic [31:0] ret_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_cnt_q <= '0;
        end else if (consume_c && !bus.Flush) begin
            ret_cnt_q <= ret_cnt_q + 32'd1;
        end
    end

    assign bus.InstRetCnt = ret_cnt_q;
`else
    assign bus.InstRetCnt = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. The bench plays imem
// (1-cycle response, word = function of address) and decode.
module tb_fetch_unit;
    logic clk;
    logic rst_n;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pcsrc;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[7];
    int   n_vec;
    int   n_err;
    int   n_consume;
    bit   auto_rsp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef FETCH_PERF_CNT_EN
        return 32'(n_consume);
`else
        return 32'd0;
`endif
    endfunction

    // one clock; imem answers an accepted request in the following cycle
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = bus.ImemReq & bus.ImemReady;
        a   = bus.ImemAddr;
        @(posedge clk);
        #1;
        if (acc && auto_rsp) begin
            bus.ImemRspValid = 1'b1;
            bus.ImemRdata    = mem_word(a);
        end else begin
            bus.ImemRspValid = 1'b0;
            bus.ImemRdata    = 32'h0;
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.InstrValid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.InstrValid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: InstrValid timeout got 0 expected 1", name);
        end
    endtask

    task automatic consume(input logic pcsrc, input logic [31:0] target);
        bus.InstrReady = 1'b1;
        bus.PCSrc      = pcsrc;
        bus.PCTarget   = target;
        tick();
        bus.InstrReady = 1'b0;
        bus.PCSrc      = 1'b0;
        bus.PCTarget   = 32'h0;
        n_consume++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_err = 0; n_consume = 0; auto_rsp = 1'b1;
        vecs[0] = '{1'b0, 32'hDEAD_BEE0, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{1'b1, 32'h0000_0200, 32'h0000_0104, 32'h0000_0200};
        vecs[2] = '{1'b1, 32'h0000_0301, 32'h0000_0200, 32'h0000_0300};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0300, 32'h0000_0304};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0304, 32'hFFFF_FFFC};
        vecs[5] = '{1'b0, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[6] = '{1'b1, 32'h0000_0044, 32'h0000_0000, 32'h0000_0044};

        rst_n = 1'b0;
        bus.ImemReady = 1'b1; bus.ImemRspValid = 1'b0; bus.ImemRdata = 32'h0;
        bus.InstrReady = 1'b0; bus.PCSrc = 1'b0; bus.PCTarget = 32'h0;
        bus.Flush = 1'b0; bus.FlushPC = 32'h0;

        // reset values
        #12;
        chk("rst_req", 32'(bus.ImemReq), 32'd0);
        chk("rst_valid", 32'(bus.InstrValid), 32'd0);
        chk("rst_instr", bus.Instr, 32'h0000_0013);
        chk("rst_pc", bus.PC, 32'h0000_0100);
        chk("rst_pcp4", bus.PCPlus4, 32'h0000_0104);
        chk("rst_mis", 32'(bus.MisalignErr), 32'd0);
        chk("rst_cnt", bus.InstRetCnt, 32'd0);

        // first fetch latency after reset release
        @(posedge clk); #1; rst_n = 1'b1;
        tick();
        chk("c1_req", 32'(bus.ImemReq), 32'd1);
        chk("c1_addr", bus.ImemAddr, 32'h0000_0100);
        chk("c1_valid", 32'(bus.InstrValid), 32'd0);
        tick();
        chk("c2_valid", 32'(bus.InstrValid), 32'd0);
        chk("c2_req", 32'(bus.ImemReq), 32'd0);
        tick();
        chk("c3_valid", 32'(bus.InstrValid), 32'd1);
        chk("c3_instr", bus.Instr, 32'h0050_0093);

        // consume table: next PC selection, target bit0 clearing, wrap
        foreach (vecs[i]) begin
            wait_valid($sformatf("v%0d_wait", i));
            chk($sformatf("v%0d_pc", i), bus.PC, vecs[i].exp_pc);
            chk($sformatf("v%0d_pcp4", i), bus.PCPlus4, vecs[i].exp_pc + 32'd4);
            chk($sformatf("v%0d_instr", i), bus.Instr, mem_word(vecs[i].exp_pc));
            consume(vecs[i].pcsrc, vecs[i].target);
            chk($sformatf("v%0d_valid", i), 32'(bus.InstrValid), 32'd0);
            chk($sformatf("v%0d_req", i), 32'(bus.ImemReq), 32'd1);
            chk($sformatf("v%0d_addr", i), bus.ImemAddr, vecs[i].exp_next);
        end
        chk("cnt_after_table", bus.InstRetCnt, exp_cnt());

        // imem not ready for 5 cycles: request held stable
        bus.ImemReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("stall%0d_req", k), 32'(bus.ImemReq), 32'd1);
            chk($sformatf("stall%0d_addr", k), bus.ImemAddr, 32'h0000_0044);
        end
        bus.ImemReady = 1'b1;
        wait_valid("stall_wait");

        // decode not ready for 4 cycles; a stray response is ignored
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                bus.ImemRspValid = 1'b1;
                bus.ImemRdata    = 32'h1234_5678;
            end
            tick();
            chk($sformatf("hold%0d_valid", k), 32'(bus.InstrValid), 32'd1);
            chk($sformatf("hold%0d_instr", k), bus.Instr, mem_word(32'h0000_0044));
            chk($sformatf("hold%0d_pc", k), bus.PC, 32'h0000_0044);
        end
        consume(1'b0, 32'h0);

        // flush while waiting; the stale response must be dropped
        auto_rsp = 1'b0;
        tick();
        chk("fw_req", 32'(bus.ImemReq), 32'd0);
        bus.Flush = 1'b1; bus.FlushPC = 32'h0000_0403;
        tick();
        bus.Flush = 1'b0; bus.FlushPC = 32'h0;
        chk("fw_pc", bus.PC, 32'h0000_0400);
        chk("fw_req2", 32'(bus.ImemReq), 32'd0);
        bus.ImemRspValid = 1'b1; bus.ImemRdata = 32'hDEAD_BEEF;
        tick();
        auto_rsp = 1'b1;
        chk("fw_valid", 32'(bus.InstrValid), 32'd0);
        chk("fw_refetch_req", 32'(bus.ImemReq), 32'd1);
        chk("fw_refetch_addr", bus.ImemAddr, 32'h0000_0400);
        wait_valid("fw_wait");
        chk("fw_instr", bus.Instr, mem_word(32'h0000_0400));
        chk("fw_pc2", bus.PC, 32'h0000_0400);

        // misaligned target: one-cycle error pulse, halt until flush
        chk("mis_pre", 32'(bus.MisalignErr), 32'd0);
        consume(1'b1, 32'h0000_0302);
        chk("mis_pulse", 32'(bus.MisalignErr), 32'd1);
        chk("mis_valid", 32'(bus.InstrValid), 32'd0);
        chk("mis_pc", bus.PC, 32'h0000_0400);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("halt%0d_mis", k), 32'(bus.MisalignErr), 32'd0);
            chk($sformatf("halt%0d_req", k), 32'(bus.ImemReq), 32'd0);
        end
        bus.Flush = 1'b1; bus.FlushPC = 32'h0000_0500;
        tick();
        bus.Flush = 1'b0; bus.FlushPC = 32'h0;
        chk("resume_req", 32'(bus.ImemReq), 32'd1);
        chk("resume_addr", bus.ImemAddr, 32'h0000_0500);
        wait_valid("resume_wait");
        chk("resume_pc", bus.PC, 32'h0000_0500);
        consume(1'b0, 32'h0);
        wait_valid("c10_wait");
        chk("c10_pc", bus.PC, 32'h0000_0504);

        // flush beats a simultaneous consume and does not count
        bus.InstrReady = 1'b1; bus.PCSrc = 1'b1; bus.PCTarget = 32'h0000_0900;
        bus.Flush = 1'b1; bus.FlushPC = 32'h0000_0600;
        tick();
        bus.InstrReady = 1'b0; bus.PCSrc = 1'b0; bus.PCTarget = 32'h0;
        bus.Flush = 1'b0;
        chk("fv_valid", 32'(bus.InstrValid), 32'd0);
        chk("fv_addr", bus.ImemAddr, 32'h0000_0600);
        chk("fv_cnt", bus.InstRetCnt, exp_cnt());

        // flush on the accept cycle: the returning word is discarded
        bus.Flush = 1'b1; bus.FlushPC = 32'h0000_0700;
        tick();
        bus.Flush = 1'b0; bus.FlushPC = 32'h0;
        chk("fa_req", 32'(bus.ImemReq), 32'd0);
        tick();
        chk("fa_valid", 32'(bus.InstrValid), 32'd0);
        chk("fa_req2", 32'(bus.ImemReq), 32'd1);
        chk("fa_addr", bus.ImemAddr, 32'h0000_0700);
        wait_valid("fa_wait");
        chk("fa_pc", bus.PC, 32'h0000_0700);
        chk("fa_instr", bus.Instr, mem_word(32'h0000_0700));
        chk("final_cnt", bus.InstRetCnt, exp_cnt());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
